// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its surroundings.
//   - timing from vga_sync: displayEnable, xIndex, yIndex
//   - writer request:       wr_valid, wr_addr, wr_data, wr_ready
//   - single-port RAM:      ram_addr, ram_we, ram_wdata, ram_rdata
//   - scan-out and status:  pixel_out, fetch_busy, fetch_overrun
// The slave modport is the arbiter's view. The master modport is the view
// of the environment: the sync generator, the writer, the RAM and the DAC.
`timescale 1ns/1ps
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 8
) ();
  logic              displayEnable;
  logic [9:0]        xIndex;
  logic [9:0]        yIndex;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata;
  logic [PIX_W-1:0]  pixel_out;
  logic              fetch_busy;
  logic              fetch_overrun;

  modport master (
    output displayEnable, xIndex, yIndex, wr_valid, wr_addr, wr_data, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata, pixel_out, fetch_busy, fetch_overrun
  );

  modport slave (
    input  displayEnable, xIndex, yIndex, wr_valid, wr_addr, wr_data, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata, pixel_out, fetch_busy, fetch_overrun
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM (1-cycle read
// latency) between VGA scan-out and one pixel writer.
// During the scanline before each low-res row is shown, that row is
// prefetched into one bank of a 2-bank line buffer. The writer gets every
// RAM cycle the prefetch does not use. When both want the same cycle, the
// grant alternates strictly between them.
// Scan-out upscales the framebuffer by 2^SCALE_LOG2 in both x and y.
// Ports:
//   clk  pixel clock, shared with vga_sync
//   rst  synchronous, active-high reset
//   bus  vga_fb_arbiter_if.slave: sync timing in, writer handshake,
//        RAM port, pixel_out, fetch_busy, fetch_overrun (sticky)
`timescale 1ns/1ps
module vga_fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 15,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input logic             clk,
  input logic             rst,
  vga_fb_arbiter_if.slave bus
);
  localparam int COL_W = $clog2(FB_W + 1);
  localparam int IDX_W = $clog2(FB_W);

  typedef enum logic {IDLE, FETCH} state_t;
  typedef enum logic {WRITER, FETCHER} owner_t;

  state_t            state, stateNext;
  owner_t            lastGrant, lastGrantNext;
  logic [COL_W-1:0]  col, colNext;
  logic [ADDR_W-1:0] rowBase, rowBaseNext;
  logic              fetchBank, fetchBankNext;
  logic              overrun, overrunNext;
  logic              prevDe;
  logic              rdPend;
  logic [IDX_W-1:0]  rdCol;
  logic              rdBank;
  logic [ADDR_W-1:0] addrHold;
  logic [PIX_W-1:0]  pixel;
  logic [PIX_W-1:0]  lineBuf [2][FB_W];

  logic [10:0]       yNext;
  logic [IDX_W-1:0]  scanCol;
  logic              trigA, trigB, wrReq, fetchReq, grantW, grantF;

  always_comb begin
    yNext   = {1'b0, bus.yIndex} + 11'd1;
    scanCol = IDX_W'(bus.xIndex >> SCALE_LOG2);
    trigA   = (bus.yIndex == 10'h3FF) && (bus.xIndex == '0) && !bus.displayEnable;
    // Both row bounds agree for a consistent configuration.
    trigB   = prevDe && !bus.displayEnable && (yNext < 11'(V_ACTIVE)) &&
              ((yNext >> SCALE_LOG2) < 11'(FB_H)) && (yNext[SCALE_LOG2-1:0] == '0);

    wrReq    = bus.wr_valid && !rst;
    fetchReq = (state == FETCH) && (col < COL_W'(FB_W)) && !rst;
    grantW   = wrReq && (!fetchReq || lastGrant == FETCHER);
    grantF   = fetchReq && (!wrReq || lastGrant == WRITER);

    bus.wr_ready  = grantW;
    bus.ram_we    = grantW;
    bus.ram_wdata = grantW ? bus.wr_data : '0;
    bus.ram_addr  = addrHold;
    if (grantW)      bus.ram_addr = bus.wr_addr;
    else if (grantF) bus.ram_addr = rowBase + ADDR_W'(col);
    bus.fetch_busy    = (state == FETCH);
    bus.fetch_overrun = overrun;
    bus.pixel_out     = pixel;

    stateNext     = state;
    colNext       = col;
    rowBaseNext   = rowBase;
    fetchBankNext = fetchBank;
    overrunNext   = overrun;
    lastGrantNext = lastGrant;
    if (wrReq && fetchReq) lastGrantNext = grantW ? WRITER : FETCHER;

    if (trigA || trigB) begin
      // A new trigger abandons any unfinished row. A read that was already
      // issued still lands in the line buffer through the read pipeline.
      stateNext = FETCH;
      colNext   = '0;
      if (state == FETCH) overrunNext = 1'b1;
      if (trigA) begin
        rowBaseNext   = '0;
        fetchBankNext = 1'b0;
      end else begin
        rowBaseNext   = rowBase + ADDR_W'(FB_W);
        fetchBankNext = ~fetchBank;
      end
    end else if (state == FETCH) begin
      // col == FB_W means the last read's data is captured this cycle.
      if (col == COL_W'(FB_W)) stateNext = IDLE;
      else if (grantF)         colNext   = col + COL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= WRITER;
      col       <= '0;
      rowBase   <= '0;
      fetchBank <= 1'b0;
      overrun   <= 1'b0;
      prevDe    <= 1'b0;
      rdPend    <= 1'b0;
      rdCol     <= '0;
      rdBank    <= 1'b0;
      addrHold  <= '0;
      pixel     <= '0;
    end else begin
      state     <= stateNext;
      lastGrant <= lastGrantNext;
      col       <= colNext;
      rowBase   <= rowBaseNext;
      fetchBank <= fetchBankNext;
      overrun   <= overrunNext;
      prevDe    <= bus.displayEnable;
      rdPend    <= grantF;
      rdCol     <= IDX_W'(col);
      rdBank    <= fetchBank;
      addrHold  <= bus.ram_addr;
      pixel     <= (bus.displayEnable && bus.xIndex < 10'(H_ACTIVE)) ?
                   lineBuf[bus.yIndex[SCALE_LOG2]][scanCol] : '0;
    end
  end

  // Line buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (rdPend) lineBuf[rdBank][rdCol] <= bus.ram_rdata;
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter. A RAM model with 1-cycle read
// latency is preloaded with mem[a] = a[7:0]. Scanlines are 800 cycles long,
// with displayEnable high for x < 640. A rule-level model of the fetch,
// arbitration and scan-out behaviour is checked on every negative clock
// edge. Hand-computed literals pin the key timings and pixel values.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  localparam int FB_W   = 160;
  localparam int ADDR_W = 15;
  localparam int PIX_W  = 8;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

  vga_fb_arbiter #(
    .FB_W(FB_W), .FB_H(120), .SCALE_LOG2(2), .PIX_W(PIX_W),
    .ADDR_W(ADDR_W), .H_ACTIVE(640), .V_ACTIVE(480)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM: read-before-write, data valid one cycle after the address.
  logic [PIX_W-1:0] mem [MEMSZ];
  initial begin
    for (int a = 0; a < MEMSZ; a++) mem[a] = 8'(a);
    forever begin
      @(posedge clk);
      if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // Behavioural model. Grants, capture and scan-out follow the rules.
  bit mValid = 0, mBusy = 0, mLastW = 1, mOvr = 0, mPend = 0, mPrevDe = 0, mPixOk = 1;
  int mCol = 0, mBase = 0, mBank = 0, mPendCol = 0, mPendBank = 0, mPendData = 0;
  int mHold = 0, mPix = 0;
  int lb [2][FB_W];
  bit lbOk [2][FB_W];

  always @(negedge clk) begin : model
    bit de, ww, fw, wwin, fwin, nOk, tA, tB;
    int x, y, ea, c, r, nPix;
    de = (bus.displayEnable === 1'b1);
    x  = int'(bus.xIndex);
    y  = int'(bus.yIndex);
    ww = (bus.wr_valid === 1'b1) && !rst;
    fw = mBusy && (mCol < FB_W) && !rst;
    wwin = ww && (!fw || !mLastW);
    fwin = fw && (!ww || mLastW);
    ea = wwin ? int'(bus.wr_addr) : (fwin ? (mBase + mCol) % MEMSZ : mHold);
    if (mValid) begin
      check("wr_ready", bus.wr_ready, wwin);
      check("ram_we", bus.ram_we, wwin);
      check("ram_addr", bus.ram_addr, ea);
      if (wwin) check("ram_wdata", bus.ram_wdata, bus.wr_data);
      check("fetch_busy", bus.fetch_busy, mBusy);
      check("fetch_overrun", bus.fetch_overrun, mOvr);
      if (mPixOk) check("pixel_out", bus.pixel_out, mPix);
    end
    nPix = 0; nOk = 1;
    if (de) begin
      c = x >> 2;
      r = (y >> 2) & 1;
      if (c < FB_W && lbOk[r][c]) nPix = lb[r][c];
      else nOk = 0;
    end
    if (mPend) begin
      lb[mPendBank][mPendCol]   = mPendData;
      lbOk[mPendBank][mPendCol] = 1;
    end
    mPend     = fwin;
    mPendCol  = mCol;
    mPendBank = mBank;
    mPendData = fwin ? int'(mem[ea]) : 0;
    if (rst) begin
      mValid = 1; mBusy = 0; mCol = 0; mBase = 0; mBank = 0; mLastW = 1;
      mOvr = 0; mPix = 0; mPixOk = 1; mHold = 0; mPrevDe = 0; mPend = 0;
    end else begin
      mHold = ea;
      mPix = nPix; mPixOk = nOk;
      if (ww && fw) mLastW = wwin;
      tA = (y == 1023) && (x == 0) && !de;
      tB = mPrevDe && !de && (y + 1 < 480) && ((y + 1) % 4 == 0);
      if (tA || tB) begin
        if (mBusy) mOvr = 1;
        mBusy = 1; mCol = 0;
        if (tA) begin mBase = 0; mBank = 0; end
        else begin mBase = (mBase + FB_W) % MEMSZ; mBank ^= 1; end
      end else if (mBusy) begin
        if (mCol == FB_W) mBusy = 0;
        else if (fwin) mCol++;
      end
      mPrevDe = de;
    end
  end

  // Stimulus side.
  bit wrOn = 0;
  int wrAddr = 20000;
  int accQ[$];
  int busyRun = 0, lastRun = 0;

  task automatic idleCycle(input bit r, input bit wv, input int a, input int d);
    @(posedge clk); #1;
    rst = r;
    bus.displayEnable = 1'b0; bus.xIndex = 10'd700; bus.yIndex = 10'd500;
    bus.wr_valid = wv; bus.wr_addr = 15'(a); bus.wr_data = 8'(d);
    #1;
  endtask

  task automatic runLine(input int y, input bit glitch, input bit midReset);
    for (int x = 0; x < 800; x++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      bus.displayEnable = (x < 640) && (y < 480);
      bus.xIndex = 10'(x);
      bus.yIndex = 10'(y);
      if (glitch && x == 700) begin bus.displayEnable = 1'b1; bus.xIndex = '0; end
      if (midReset && x == 721) rst = 1'b1;
      if (midReset && x == 722) wrOn = 1;
      if (midReset && x == 740) wrOn = 0;
      if (y == 7 && x == 600) wrOn = 1;
      if (y == 8 && x == 400) wrOn = 0;
      bus.wr_valid = wrOn;
      bus.wr_addr  = 15'(wrAddr);
      bus.wr_data  = 8'(wrAddr) ^ 8'h5A;
      #1;
      if (wrOn && bus.wr_ready === 1'b1) begin accQ.push_back(wrAddr); wrAddr++; end
      if (bus.fetch_busy === 1'b1) busyRun++;
      else if (busyRun > 0) begin lastRun = busyRun; busyRun = 0; end
      if (y == 1023 && x == 1)   check("lit_first_read_addr", bus.ram_addr, 0);
      if (y == 1023 && x == 1)   check("lit_first_read_we", bus.ram_we, 0);
      if (y == 1023 && x == 160) check("lit_last_read_addr", bus.ram_addr, 159);
      if (y == 0 && x >= 1 && x <= 8) check("lit_line0_pixel", bus.pixel_out, (x - 1) >> 2);
      if ((y < 3 || y == 479) && x == 700) check("lit_no_fetch", bus.fetch_busy, 0);
      if (y == 3 && x == 641) check("lit_row1_addr", bus.ram_addr, 160);
      if (y == 4 && x == 5)   check("lit_line4_pixel", bus.pixel_out, 8'hA1);
      if (glitch && x == 702) check("lit_overrun_set", bus.fetch_overrun, 1);
      if (glitch && x == 702) check("lit_restart_addr", bus.ram_addr, 640);
      if (midReset && x == 720) check("lit_overrun_sticky", bus.fetch_overrun, 1);
      if (midReset && x == 722) begin
        check("lit_rst_busy", bus.fetch_busy, 0);
        check("lit_rst_overrun", bus.fetch_overrun, 0);
        check("lit_rst_pixel", bus.pixel_out, 0);
        check("lit_rst_wr_ready", bus.wr_ready, 1);
      end
    end
  endtask

  initial begin
    bus.displayEnable = 1'b0; bus.xIndex = '0; bus.yIndex = 10'd500;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) idleCycle(1, 0, 0, 0);
    idleCycle(0, 0, 0, 0);
    check("lit_reset_busy", bus.fetch_busy, 0);
    check("lit_reset_overrun", bus.fetch_overrun, 0);
    check("lit_reset_pixel", bus.pixel_out, 0);
    check("lit_reset_we", bus.ram_we, 0);

    idleCycle(0, 1, 5, 8'hA5);
    check("lit_idle_wr_ready", bus.wr_ready, 1);
    check("lit_idle_we", bus.ram_we, 1);
    check("lit_idle_addr", bus.ram_addr, 5);
    check("lit_idle_wdata", bus.ram_wdata, 8'hA5);
    idleCycle(0, 1, 5, 8'h05);
    check("lit_idle_mem", mem[5], 8'hA5);
    idleCycle(0, 0, 0, 0);
    check("lit_idle_mem_restored", mem[5], 8'h05);

    runLine(1023, 0, 0);
    check("lit_frame_fetch_cycles", lastRun, 161);
    for (int y = 0; y < 16; y++) begin
      runLine(y, y == 11, y == 15);
      if (y == 8) check("lit_contended_fetch_cycles", lastRun, 320);
    end
    for (int y = 475; y < 480; y++) runLine(y, 0, 0);
    runLine(1023, 0, 0);
    check("lit_clean_refetch_cycles", lastRun, 161);
    for (int y = 0; y < 5; y++) runLine(y, 0, 0);
    idleCycle(0, 0, 0, 0);

    foreach (accQ[i]) check("writer_mem", mem[accQ[i]], 8'(accQ[i]) ^ 8'h5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
